// File: rtl/serial_mod_checker.sv
// serial_mod_checker
//
// Computes, bit by bit, the remainder of a serially received binary number
// modulo MOD. Frames are delimited by sof/eof beats qualified by in_valid.
// The bit order (MSB-first or LSB-first) is chosen per frame by mode_lsb on
// the sof beat. The remainder is maintained incrementally with one
// conditional subtract per beat, so no divider is required.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   qualifies in_bit, sof, eof, mode_lsb
//   in_bit     serial data bit
//   sof        first beat of a frame
//   eof        last beat of a frame
//   mode_lsb   bit order, sampled on sof beats: 0 = MSB-first, 1 = LSB-first
//   rem        running remainder of the current (or last) frame
//   div_now    rem == 0
//   res_valid  one-cycle pulse, the cycle after an accepted eof beat
//   res_rem    final remainder of the last completed frame (held)
//   res_div    res_rem == 0 (held)
//   bit_cnt    bits accepted in the current or last frame, saturating
//   cnt_sat    set once bit_cnt has reached its maximum in this frame
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE  | no open frame; only a sof beat is accepted
// ACTIVE| frame open; every valid beat updates rem, eof closes it

module serial_mod_checker #(
    parameter int MOD   = 5,
    parameter int CNT_W = 16,
    localparam int RW   = ($clog2(MOD) < 1) ? 1 : $clog2(MOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             sof,
    input  logic             eof,
    input  logic             mode_lsb,
    output logic [RW-1:0]    rem,
    output logic             div_now,
    output logic             res_valid,
    output logic [RW-1:0]    res_rem,
    output logic             res_div,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             cnt_sat
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam logic [RW:0]      MOD_X   = (RW+1)'(MOD);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state;
    logic [RW-1:0]    rem_q;
    logic [RW-1:0]    w_q;
    logic             mode_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             cnt_sat_q;
    logic             res_valid_q;
    logic [RW-1:0]    res_rem_q;
    logic             res_div_q;

    logic             accept;
    logic             mode_eff;
    logic [RW-1:0]    base_rem;
    logic [RW-1:0]    base_w;
    logic [RW:0]      msb_sum;
    logic [RW:0]      lsb_sum;
    logic [RW:0]      w_dbl;
    logic [RW-1:0]    rem_next;
    logic [RW-1:0]    w_next;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;

    // Both operands are already below MOD, so every sum is below 2*MOD and a
    // single conditional subtract completes the reduction.
    function automatic logic [RW-1:0] mod_reduce(input logic [RW:0] x);
        return RW'((x >= MOD_X) ? (x - MOD_X) : x);
    endfunction

    // Outside a frame only sof opens one; everything else is dropped.
    assign accept = in_valid && (sof || (state == ACTIVE));

    // A sof beat starts from a clean slate (rem 0, weight 1) on the same beat,
    // which also covers restarting an open frame.
    assign mode_eff = sof ? mode_lsb : mode_q;
    assign base_rem = sof ? '0 : rem_q;
    assign base_w   = sof ? RW'(1) : w_q;

    // {rem, bit} is exactly 2*rem + bit.
    assign msb_sum = {base_rem, in_bit};
    assign lsb_sum = {1'b0, base_rem} + ({1'b0, base_w} & {(RW+1){in_bit}});
    assign w_dbl   = {base_w, 1'b0};

    always_comb begin
        rem_next = '0;
        w_next   = base_w;
        if (mode_eff) begin
            rem_next = mod_reduce(lsb_sum);
            w_next   = mod_reduce(w_dbl);
        end else begin
            rem_next = mod_reduce(msb_sum);
        end
    end

    always_comb begin
        cnt_next = bit_cnt_q;
        sat_next = cnt_sat_q;
        if (sof) begin
            cnt_next = CNT_W'(1);
            sat_next = 1'b0;
        end else if (bit_cnt_q != CNT_MAX) begin
            cnt_next = bit_cnt_q + CNT_W'(1);
        end
        if (cnt_next == CNT_MAX) begin
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem_q       <= '0;
            w_q         <= RW'(1);
            mode_q      <= 1'b0;
            bit_cnt_q   <= '0;
            cnt_sat_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_rem_q   <= '0;
            res_div_q   <= 1'b0;
        end else begin
            res_valid_q <= accept && eof;
            if (accept) begin
                state     <= eof ? IDLE : ACTIVE;
                rem_q     <= rem_next;
                w_q       <= w_next;
                bit_cnt_q <= cnt_next;
                cnt_sat_q <= sat_next;
                if (sof) begin
                    mode_q <= mode_lsb;
                end
                if (eof) begin
                    res_rem_q <= rem_next;
                    res_div_q <= (rem_next == '0);
                end
            end
        end
    end

    assign rem       = rem_q;
    assign div_now   = (rem_q == '0);
    assign res_valid = res_valid_q;
    assign res_rem   = res_rem_q;
    assign res_div   = res_div_q;
    assign bit_cnt   = bit_cnt_q;
    assign cnt_sat   = cnt_sat_q;

endmodule

// File: tb/tb_serial_mod_checker.sv
module tb_serial_mod_checker;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_bit = 1'b0, sof = 1'b0, eof = 1'b0, mode_lsb = 1'b0;

    logic [2:0]    rem5, res_rem5;
    logic          div_now5, res_valid5, res_div5, cnt_sat5;
    logic [CW-1:0] bit_cnt5;
    logic [1:0]    rem3, res_rem3;
    logic          div_now3, res_valid3, res_div3, cnt_sat3;
    logic [CW-1:0] bit_cnt3;

    serial_mod_checker #(.MOD(5), .CNT_W(CW)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .sof(sof), .eof(eof), .mode_lsb(mode_lsb),
        .rem(rem5), .div_now(div_now5), .res_valid(res_valid5),
        .res_rem(res_rem5), .res_div(res_div5), .bit_cnt(bit_cnt5), .cnt_sat(cnt_sat5)
    );

    serial_mod_checker #(.MOD(3), .CNT_W(CW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .sof(sof), .eof(eof), .mode_lsb(mode_lsb),
        .rem(rem3), .div_now(div_now3), .res_valid(res_valid3),
        .res_rem(res_rem3), .res_div(res_div3), .bit_cnt(bit_cnt3), .cnt_sat(cnt_sat3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: the bits of the current/last frame and its bit order.
    bit fbits[$];
    bit m_active = 1'b0;
    bit m_lsb = 1'b0;

    typedef struct { int r; int c; } exp_t;
    exp_t q5[$];
    exp_t q3[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Value of the frame bits modulo m, read in the frame's bit order.
    function automatic int mrem(int m);
        int v = 0;
        int p = 1;
        for (int i = 0; i < fbits.size(); i++) begin
            if (m_lsb) begin
                v = (v + int'(fbits[i]) * p) % m;
                p = (p * 2) % m;
            end else begin
                v = (v * 2 + int'(fbits[i])) % m;
            end
        end
        return v;
    endfunction

    function automatic int mcnt();
        return (fbits.size() > CMAX) ? CMAX : fbits.size();
    endfunction

    // Monitor: running outputs every cycle, results popped from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        check("rem5", rem5, mrem(5));
        check("div_now5", div_now5, mrem(5) == 0);
        check("rem3", rem3, mrem(3));
        check("div_now3", div_now3, mrem(3) == 0);
        check("bit_cnt5", bit_cnt5, mcnt());
        check("bit_cnt3", bit_cnt3, mcnt());
        check("cnt_sat5", cnt_sat5, fbits.size() >= CMAX);
        check("cnt_sat3", cnt_sat3, fbits.size() >= CMAX);

        if (res_valid5) begin
            if (q5.size() == 0) begin
                check("res_valid5_unexpected", res_valid5, 0);
            end else begin
                e = q5.pop_front();
                check("res_rem5", res_rem5, e.r);
                check("res_div5", res_div5, e.r == 0);
                check("res_cycle5", cyc, e.c);
            end
        end else if (q5.size() > 0 && q5[0].c < cyc) begin
            check("res_valid5_missing", res_valid5, 1);
            void'(q5.pop_front());
        end

        if (res_valid3) begin
            if (q3.size() == 0) begin
                check("res_valid3_unexpected", res_valid3, 0);
            end else begin
                e = q3.pop_front();
                check("res_rem3", res_rem3, e.r);
                check("res_div3", res_div3, e.r == 0);
                check("res_cycle3", cyc, e.c);
            end
        end else if (q3.size() > 0 && q3[0].c < cyc) begin
            check("res_valid3_missing", res_valid3, 1);
            void'(q3.pop_front());
        end
    end

    task automatic beat(bit v, bit b, bit s, bit e, bit m);
        @(negedge clk);
        #1;
        in_valid = v; in_bit = b; sof = s; eof = e; mode_lsb = m;
        @(posedge clk);
        #1;
        if (v && (s || m_active)) begin
            if (s) begin
                fbits.delete();
                m_lsb = m;
            end
            fbits.push_back(b);
            if (e) begin
                q5.push_back('{mrem(5), cyc});
                q3.push_back('{mrem(3), cyc});
                m_active = 1'b0;
            end else begin
                m_active = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic gap_beats(int n);
        for (int i = 0; i < n; i++)
            beat(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        fbits.delete();
        m_active = 1'b0;
        m_lsb = 1'b0;
        q5.delete();
        q3.delete();
        #1;
        check("rst_rem5", rem5, 0);
        check("rst_div_now5", div_now5, 1);
        check("rst_res_valid5", res_valid5, 0);
        check("rst_res_rem5", res_rem5, 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #22;
        check("reset_rem5", rem5, 0);
        check("reset_div_now5", div_now5, 1);
        check("reset_bit_cnt5", bit_cnt5, 0);
        rst_n = 1'b1;

        // MSB-first 13 mod 5
        beat(1, 1, 1, 0, 0); beat(1, 1, 0, 0, 0); beat(1, 0, 0, 0, 0); beat(1, 1, 0, 1, 0);
        check("msb13_res_rem5", res_rem5, 3);
        check("msb13_res_div5", res_div5, 0);
        check("msb13_bit_cnt5", bit_cnt5, 4);

        // LSB-first 13, mode flipped mid-frame must be ignored
        beat(1, 1, 1, 0, 1); beat(1, 0, 0, 0, 0); beat(1, 1, 0, 0, 1); beat(1, 1, 0, 1, 0);
        check("lsb13_res_rem5", res_rem5, 3);
        // MSB-first 10
        beat(1, 1, 1, 0, 0); beat(1, 0, 0, 0, 1); beat(1, 1, 0, 0, 1); beat(1, 0, 0, 1, 1);
        check("msb10_res_rem5", res_rem5, 0);
        check("msb10_res_div5", res_div5, 1);

        // Single-beat frame, then a non-sof beat proves the FSM stayed idle
        beat(1, 1, 1, 1, 0);
        check("single_res_rem5", res_rem5, 1);
        check("single_bit_cnt5", bit_cnt5, 1);
        beat(1, 0, 0, 1, 0);
        beat(1, 1, 0, 0, 0);

        // Aborted frame, then 7 mod 3
        beat(1, 1, 1, 0, 0); beat(1, 1, 0, 0, 0);
        beat(1, 1, 1, 0, 0); beat(1, 1, 0, 0, 0); beat(1, 1, 0, 1, 0);
        check("abort_res_rem3", res_rem3, 1);
        check("abort_bit_cnt3", bit_cnt3, 3);

        // Gapped repeat of the MSB-first 13 frame
        beat(1, 1, 1, 0, 0); gap_beats($urandom_range(0, 5));
        beat(1, 1, 0, 0, 0); gap_beats($urandom_range(0, 5));
        beat(1, 0, 0, 0, 0); gap_beats($urandom_range(0, 5));
        beat(1, 1, 0, 1, 0);
        check("gap_res_rem5", res_rem5, 3);
        beat(1, 1, 0, 0, 1);

        // Reset mid-frame, then an orphan eof
        beat(1, 1, 1, 0, 0); beat(1, 1, 0, 0, 0);
        do_reset();
        beat(1, 1, 0, 1, 0);
        beat(1, 0, 0, 0, 0);

        // Randomized traffic, long frames exercise counter saturation
        for (int i = 0; i < 3000; i++) begin
            beat(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom));
            if (i == 1500) do_reset();
        end

        repeat (3) @(negedge clk);
        #1;
        check("q5_drained", q5.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
